// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: decode-side link (allowin, branch redirect, fs->ds bus)
// plus the SRAM-like instruction request/response channel.
interface if_stage_if #(
  parameter int FS_TO_DS_BUS_WD = 64,
  parameter int BR_BUS_WD       = 33
);
  logic                       ds_allowin;
  logic [BR_BUS_WD-1:0]       br_bus;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       inst_sram_req;
  logic [31:0]                inst_sram_addr;
  logic                       inst_sram_addr_ok;
  logic                       inst_sram_data_ok;
  logic [31:0]                inst_sram_rdata;

  // Fetch stage side
  modport master (
    input  ds_allowin, br_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_addr
  );

  // Decode stage / instruction memory side
  modport slave (
    output ds_allowin, br_bus, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_addr
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: pre-IF PC generation / request issue, IF wait-for-data
// with a one-entry instruction buffer and wrong-path response discard.
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          FS_TO_DS_BUS_WD = 64,
  parameter int          BR_BUS_WD       = 33
) (
  input logic        clk,
  input logic        reset,
  if_stage_if.master bus
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  // pre-IF state
  logic        pfs_valid;
  logic [31:0] pfs_pc;
  // IF state
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [1:0]  discard_cnt;

  logic [BR_BUS_WD-1:0]       br_bus_w;
  logic                       br_taken;
  logic [31:0]                br_target;
  logic                       redirect;
  logic                       fs_ready_go;
  logic                       fs_allowin;
  logic                       fs_leave;
  logic                       hs;
  logic                       buf_fill;
  logic                       discard_inc;
  logic                       discard_dec;
  fs_to_ds_t                  fs_out;
  logic [FS_TO_DS_BUS_WD-1:0] fs_out_w;

  assign br_bus_w              = bus.br_bus;
  assign {br_taken, br_target} = br_bus_w[32:0];

  // A taken branch only acts in the cycle it actually leaves decode.
  assign redirect    = br_taken & bus.ds_allowin;
  assign fs_ready_go = buf_valid | (bus.inst_sram_data_ok & (discard_cnt == 2'd0));
  assign fs_allowin  = ~fs_valid | (fs_ready_go & bus.ds_allowin) | redirect;

  assign bus.inst_sram_req  = pfs_valid & fs_allowin & ~reset;
  assign bus.inst_sram_addr = redirect ? br_target : pfs_pc;
  assign hs                 = bus.inst_sram_req & bus.inst_sram_addr_ok;

  // Zero-cycle bypass: returning data goes straight to decode when nothing is buffered.
  assign bus.fs_to_ds_valid = fs_valid & fs_ready_go & ~redirect & ~reset;
  assign fs_leave           = bus.fs_to_ds_valid & bus.ds_allowin;
  assign fs_out.inst        = buf_valid ? buf_inst : bus.inst_sram_rdata;
  assign fs_out.pc          = fs_pc;
  assign fs_out_w           = fs_out;
  assign bus.fs_to_ds_bus   = fs_out_w;

  // Data for the live request arrives while decode is stalled: park it.
  assign buf_fill    = bus.inst_sram_data_ok & (discard_cnt == 2'd0) & fs_valid
                     & ~bus.ds_allowin & ~redirect;
  // Squashing a request still in flight leaves one orphan response to drop.
  assign discard_inc = redirect & fs_valid & ~fs_ready_go;
  assign discard_dec = bus.inst_sram_data_ok & (discard_cnt != 2'd0);

  // Next fetch PC: sequential after a handshake, otherwise follow a redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pfs_valid <= 1'b0;
      pfs_pc    <= RESET_PC;
    end else begin
      pfs_valid <= 1'b1;
      if (hs)            pfs_pc <= bus.inst_sram_addr + 32'd4;
      else if (redirect) pfs_pc <= br_target;
    end
  end

  // IF slot: occupied by each accepted request, freed on hand-off or squash.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= '0;
    end else if (hs) begin
      fs_valid <= 1'b1;
      fs_pc    <= bus.inst_sram_addr;
    end else if (fs_leave | redirect) begin
      fs_valid <= 1'b0;
    end
  end

  // One-entry instruction buffer covering a decode stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_inst  <= '0;
    end else if (fs_leave | redirect) begin
      buf_valid <= 1'b0;
    end else if (buf_fill) begin
      buf_valid <= 1'b1;
      buf_inst  <= bus.inst_sram_rdata;
    end
  end

  // Count of wrong-path responses still to be dropped; saturating.
  always_ff @(posedge clk) begin
    if (reset)
      discard_cnt <= 2'd0;
    else if (discard_inc & ~discard_dec & (discard_cnt != 2'd3))
      discard_cnt <= discard_cnt + 2'd1;
    else if (discard_dec & ~discard_inc)
      discard_cnt <= discard_cnt - 2'd1;
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order SRAM model with per-request latency and a
// scoreboard of expected {inst, pc} words consumed by decode.
module tb_if_stage;
  localparam logic [31:0] RC = 32'h1c000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus ();
  if_stage dut (.clk(clk), .reset(reset), .bus(bus.master));

  typedef struct {
    logic [31:0] addr;
    int          rem;
  } pend_t;

  pend_t       pq[$];
  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        aok = 1'b1;
  logic        hold = 1'b0;
  logic        sb_auto = 1'b0;
  int          lat = 1;
  logic [31:0] nxt = RC;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hdeadbeef;
  endfunction

  // Instruction SRAM model: accept on posedge, respond in order after lat cycles.
  initial forever begin
    @(posedge clk);
    if (reset) pq.delete();
    else if (bus.inst_sram_req === 1'b1 && bus.inst_sram_addr_ok === 1'b1) begin
      pq.push_back('{addr: bus.inst_sram_addr, rem: lat});
      if (sb_auto) begin
        n_vec++;
        if (bus.inst_sram_addr !== nxt) begin
          n_err++; $display("FAIL seq_addr: got %h want %h", bus.inst_sram_addr, nxt);
        end
        exp_q.push_back({inst_of(nxt), nxt});
        nxt = nxt + 32'd4;
      end
    end
    @(negedge clk); #1;
    bus.inst_sram_addr_ok = aok;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = 32'hbad0bad0;
    if (!hold && pq.size() > 0) begin
      if (pq[0].rem <= 1) begin
        bus.inst_sram_data_ok = 1'b1;
        bus.inst_sram_rdata   = inst_of(pq[0].addr);
        void'(pq.pop_front());
      end else begin
        pq[0].rem = pq[0].rem - 1;
      end
    end
  end

  // Scoreboard: every instruction taken by decode must match the next expected word.
  initial forever begin
    logic [63:0] e;
    @(negedge clk); #3;
    if (!reset && bus.fs_to_ds_valid === 1'b1 && bus.ds_allowin === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL sb_unexpected: got %h want no delivery", bus.fs_to_ds_bus);
      end else begin
        e = exp_q.pop_front();
        if (bus.fs_to_ds_bus !== e) begin
          n_err++; $display("FAIL sb_bus: got %h want %h", bus.fs_to_ds_bus, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
    reset = 1'b1; bus.ds_allowin = 1'b0; bus.br_bus = '0;
    aok = 1'b1; hold = 1'b0; lat = 1; sb_auto = 1'b0;
    step(); step();
    reset = 1'b0; bus.ds_allowin = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    step(); reset = 1'b1; bus.ds_allowin = 1'b1; bus.br_bus = '0;
    step(); step(); settle();
    n_vec++; if (bus.inst_sram_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus.inst_sram_req); end
    n_vec++; if (bus.fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.fs_to_ds_valid); end
    step(); reset = 1'b0; settle();
    n_vec++; if (bus.inst_sram_req !== 1'b0) begin n_err++; $display("FAIL rel_req: got %b want 0", bus.inst_sram_req); end
    step(); settle();
    n_vec++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== RC) begin
      n_err++; $display("FAIL first_req: got %b/%h want 1/%h", bus.inst_sram_req, bus.inst_sram_addr, RC); end
    step(); settle();
    exp_q.push_back({inst_of(RC), RC});
    // Reset mid-stream: outputs drop at once, fetch restarts from RESET_PC.
    step(); reset = 1'b1; settle();
    n_vec++; if (bus.inst_sram_req !== 1'b0) begin n_err++; $display("FAIL mid_rst_req: got %b want 0", bus.inst_sram_req); end
    n_vec++; if (bus.fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus.fs_to_ds_valid); end
    step(); reset = 1'b0; settle();
    step(); settle();
    n_vec++; if (bus.inst_sram_addr !== RC) begin n_err++; $display("FAIL restart_addr: got %h want %h", bus.inst_sram_addr, RC); end
    step(); settle();
    exp_q.push_back({inst_of(RC), RC});
    n_vec++; if (bus.fs_to_ds_valid !== 1'b1) begin n_err++; $display("FAIL restart_valid: got %b want 1", bus.fs_to_ds_valid); end
  endtask

  task automatic test_seq_fetch();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(); settle();
      n_vec++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== RC + 32'(4 * i)) begin
        n_err++; $display("FAIL seq_req%0d: got %b/%h want 1/%h", i, bus.inst_sram_req, bus.inst_sram_addr, RC + 32'(4 * i)); end
      if (i > 0) begin
        exp_q.push_back({inst_of(RC + 32'(4 * (i - 1))), RC + 32'(4 * (i - 1))});
        n_vec++; if (bus.fs_to_ds_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid%0d: got %b want 1", i, bus.fs_to_ds_valid); end
      end
    end
  endtask

  task automatic test_buffer();
    do_reset();
    step(); settle();
    step(); settle(); exp_q.push_back({inst_of(RC), RC});
    step(); settle(); exp_q.push_back({inst_of(RC + 32'd4), RC + 32'd4});
    step(); bus.ds_allowin = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus.inst_sram_req !== 1'b0) begin n_err++; $display("FAIL buf_req%0d: got %b want 0", i, bus.inst_sram_req); end
      n_vec++; if (bus.fs_to_ds_valid !== 1'b1) begin n_err++; $display("FAIL buf_valid%0d: got %b want 1", i, bus.fs_to_ds_valid); end
      if (i < 2) begin step(); settle(); end
    end
    step(); bus.ds_allowin = 1'b1; exp_q.push_back({inst_of(RC + 32'd8), RC + 32'd8}); settle();
    n_vec++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== RC + 32'hc) begin
      n_err++; $display("FAIL buf_next_req: got %b/%h want 1/%h", bus.inst_sram_req, bus.inst_sram_addr, RC + 32'hc); end
    step(); settle(); exp_q.push_back({inst_of(RC + 32'hc), RC + 32'hc});
  endtask

  task automatic test_discard();
    do_reset();
    step(); settle();
    step(); settle(); exp_q.push_back({inst_of(RC), RC});
    step(); settle(); exp_q.push_back({inst_of(RC + 32'd4), RC + 32'd4});
    step(); settle(); exp_q.push_back({inst_of(RC + 32'd8), RC + 32'd8});
    step(); hold = 1'b1; bus.br_bus = {1'b1, RC + 32'h100}; settle();
    n_vec++; if (bus.fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL dis_valid: got %b want 0", bus.fs_to_ds_valid); end
    n_vec++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== RC + 32'h100) begin
      n_err++; $display("FAIL dis_req: got %b/%h want 1/%h", bus.inst_sram_req, bus.inst_sram_addr, RC + 32'h100); end
    step(); hold = 1'b0; bus.br_bus = '0; settle();
    n_vec++; if (bus.fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL dis_drop: got %b want 0", bus.fs_to_ds_valid); end
    n_vec++; if (bus.inst_sram_req !== 1'b0) begin n_err++; $display("FAIL dis_wait_req: got %b want 0", bus.inst_sram_req); end
    step(); settle(); exp_q.push_back({inst_of(RC + 32'h100), RC + 32'h100});
    n_vec++; if (bus.inst_sram_addr !== RC + 32'h104) begin n_err++; $display("FAIL dis_next: got %h want %h", bus.inst_sram_addr, RC + 32'h104); end
  endtask

  task automatic test_redirect_ready();
    do_reset();
    step(); settle();
    step(); bus.br_bus = {1'b1, RC + 32'h200}; settle();
    n_vec++; if (bus.fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL rr_valid: got %b want 0", bus.fs_to_ds_valid); end
    n_vec++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== RC + 32'h200) begin
      n_err++; $display("FAIL rr_req: got %b/%h want 1/%h", bus.inst_sram_req, bus.inst_sram_addr, RC + 32'h200); end
    step(); bus.br_bus = '0; settle(); exp_q.push_back({inst_of(RC + 32'h200), RC + 32'h200});
    n_vec++; if (bus.fs_to_ds_valid !== 1'b1) begin n_err++; $display("FAIL rr_no_discard: got %b want 1", bus.fs_to_ds_valid); end
    n_vec++; if (bus.inst_sram_addr !== RC + 32'h204) begin n_err++; $display("FAIL rr_next: got %h want %h", bus.inst_sram_addr, RC + 32'h204); end
  endtask

  task automatic test_branch_stall();
    do_reset();
    step(); settle();
    step(); bus.ds_allowin = 1'b0; bus.br_bus = {1'b1, RC + 32'h300}; settle();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus.inst_sram_req !== 1'b0 || bus.inst_sram_addr !== RC + 32'd4) begin
        n_err++; $display("FAIL bs_hold%0d: got %b/%h want 0/%h", i, bus.inst_sram_req, bus.inst_sram_addr, RC + 32'd4); end
      if (i < 2) begin step(); settle(); end
    end
    step(); bus.ds_allowin = 1'b1; settle();
    n_vec++; if (bus.fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL bs_squash: got %b want 0", bus.fs_to_ds_valid); end
    n_vec++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== RC + 32'h300) begin
      n_err++; $display("FAIL bs_req: got %b/%h want 1/%h", bus.inst_sram_req, bus.inst_sram_addr, RC + 32'h300); end
    step(); bus.br_bus = '0; settle(); exp_q.push_back({inst_of(RC + 32'h300), RC + 32'h300});
    n_vec++; if (bus.inst_sram_addr !== RC + 32'h304) begin n_err++; $display("FAIL bs_next: got %h want %h", bus.inst_sram_addr, RC + 32'h304); end
  endtask

  task automatic test_addr_stall();
    do_reset();
    aok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      n_vec++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== RC) begin
        n_err++; $display("FAIL as_wait%0d: got %b/%h want 1/%h", i, bus.inst_sram_req, bus.inst_sram_addr, RC); end
    end
    step(); bus.br_bus = {1'b1, RC + 32'h400}; settle();
    n_vec++; if (bus.inst_sram_addr !== RC + 32'h400) begin n_err++; $display("FAIL as_switch: got %h want %h", bus.inst_sram_addr, RC + 32'h400); end
    step(); bus.br_bus = '0; aok = 1'b1; settle();
    n_vec++; if (bus.inst_sram_req !== 1'b1 || bus.inst_sram_addr !== RC + 32'h400) begin
      n_err++; $display("FAIL as_keep: got %b/%h want 1/%h", bus.inst_sram_req, bus.inst_sram_addr, RC + 32'h400); end
    step(); settle(); exp_q.push_back({inst_of(RC + 32'h400), RC + 32'h400});
    n_vec++; if (bus.inst_sram_addr !== RC + 32'h404) begin n_err++; $display("FAIL as_next: got %h want %h", bus.inst_sram_addr, RC + 32'h404); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    nxt = RC; sb_auto = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      bus.ds_allowin = ($urandom_range(0, 9) < 7);
      aok = ($urandom_range(0, 9) < 6);
      lat = $urandom_range(1, 3);
    end
    step(); aok = 1'b0; bus.ds_allowin = 1'b1;
    repeat (12) step();
    sb_auto = 1'b0;
  endtask

  initial begin
    bus.ds_allowin = 1'b0;
    bus.br_bus     = '0;
    test_reset();
    test_seq_fetch();
    test_buffer();
    test_discard();
    test_redirect_ready();
    test_branch_stall();
    test_addr_stall();
    test_back_to_back();
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
